// File: rtl/skinny_sbox8_cms1_subcells_ctrl.sv
// ---------------------------------------------------------------------------
// skinny_sbox8_cms1_subcells_ctrl
//
// Byte-serial SubCells sequencer for the 2-share (CMS1) Skinny-128-384+
// datapath. A shared 128-bit state is latched, then each of its 16 cells is
// presented (one share per bus) to an external non-pipelined 8-bit CMS1
// S-box core for HOLD cycles. The core's shared outputs are written back
// into the same cell. Cell 0 (bits [127:120]) is processed first.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   s0_i, s1_i            input state, share 0 / share 1
//   rnd_i / rnd_req       fresh 32-bit mask, requested in every RUN cycle
//   sb_si0, sb_si1        registered share bytes driven to the S-box core
//   sb_r                  mask to the S-box core (rnd_i in RUN, else 0)
//   sb_bo0, sb_bo1        shared S-box core outputs
//   out_valid / out_ready output handshake; out_valid is high in DONE
//   s0_o, s1_o            result shares (direct view of the share registers)
//   busy                  high while RUN
// ---------------------------------------------------------------------------
module skinny_sbox8_cms1_subcells_ctrl #(
    parameter int HOLD = 5,     // cycles per byte: 4 AND-register layers + 1 settle
    parameter int CNTW = 3      // hold counter width, 2**CNTW > HOLD-1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] s0_i,
    input  logic [127:0] s1_i,
    input  logic [31:0]  rnd_i,
    output logic         rnd_req,
    output logic [7:0]   sb_si0,
    output logic [7:0]   sb_si1,
    output logic [31:0]  sb_r,
    input  logic [7:0]   sb_bo0,
    input  logic [7:0]   sb_bo1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] s0_o,
    output logic [127:0] s1_o,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD - 1);

    state_t         state_q;
    logic [127:0]   s0_q;
    logic [127:0]   s1_q;
    logic [3:0]     idx_q;
    logic [CNTW-1:0] cnt_q;
    logic [7:0]     si0_q;
    logic [7:0]     si1_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    // Cell i lives at bit offset 8*(15-i); 15-i is simply ~i for a 4-bit index.
    logic [3:0] idx_nx;
    logic [6:0] cur_ofs;
    logic [6:0] nxt_ofs;

    assign idx_nx  = idx_q + 4'd1;
    assign cur_ofs = {~idx_q, 3'b000};
    assign nxt_ofs = {~idx_nx, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s0_q        <= '0;
            s1_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            si0_q       <= '0;
            si1_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        s0_q       <= s0_i;
                        s1_q       <= s1_i;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        // Present cell 0 already in the first RUN cycle.
                        si0_q      <= s0_i[127:120];
                        si1_q      <= s1_i[127:120];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        // Shares stay on separate write paths and separate muxes.
                        s0_q[cur_ofs +: 8] <= sb_bo0;
                        s1_q[cur_ofs +: 8] <= sb_bo1;
                        cnt_q <= '0;
                        idx_q <= idx_nx;
                        if (idx_q == 4'd15) begin
                            // Byte buses keep their last value through DONE.
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            // Cell idx+1 has not been overwritten yet.
                            si0_q <= s0_q[nxt_ofs +: 8];
                            si1_q <= s1_q[nxt_ofs +: 8];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        // Return to IDLE with the S-box seeing constant zero shares.
                        si0_q       <= '0;
                        si1_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rnd_req   = busy_q;
    assign sb_si0    = si0_q;
    assign sb_si1    = si1_q;
    // The mask is forwarded combinationally so the core gets it in the same cycle.
    assign sb_r      = busy_q ? rnd_i : 32'd0;
    assign s0_o      = s0_q;
    assign s1_o      = s1_q;

endmodule

// File: tb/tb_skinny_sbox8_cms1_subcells_ctrl.sv
// ---------------------------------------------------------------------------
// tb_skinny_sbox8_cms1_subcells_ctrl
//
// Bench for the byte-serial CMS1 SubCells sequencer. A behavioural S-box
// core with four register layers sits on the sb_* bus; its share-0 output is
// S(x)^m and share-1 output is m, where m comes from the forwarded mask.
// Expected unmasked results are queued at accept time and popped at DONE.
// ---------------------------------------------------------------------------
module tb_skinny_sbox8_cms1_subcells_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] s0_i;
    logic [127:0] s1_i;
    logic [31:0]  rnd_i;
    logic         rnd_req;
    logic [7:0]   sb_si0;
    logic [7:0]   sb_si1;
    logic [31:0]  sb_r;
    logic [7:0]   sb_bo0;
    logic [7:0]   sb_bo1;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] s0_o;
    logic [127:0] s1_o;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] PAT = 128'h000102030405060708090A0B0C0D0E0F;

    skinny_sbox8_cms1_subcells_ctrl #(.HOLD(5), .CNTW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0_i      (s0_i),
        .s1_i      (s1_i),
        .rnd_i     (rnd_i),
        .rnd_req   (rnd_req),
        .sb_si0    (sb_si0),
        .sb_si1    (sb_si1),
        .sb_r      (sb_r),
        .sb_bo0    (sb_bo0),
        .sb_bo1    (sb_bo1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s0_o      (s0_o),
        .s1_o      (s1_o),
        .busy      (busy)
    );

    // Skinny 8-bit S-box, bit-sliced reference form.
    function automatic logic [7:0] sbox(input logic [7:0] xin);
        logic [7:0] x;
        x = xin;
        for (int r = 0; r < 4; r++) begin
            x = (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
            if (r < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
                  | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        x = (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
        return x;
    endfunction

    function automatic logic [127:0] sbox128(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(v[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural CMS1 S-box core: four register layers on shares and mask.
    logic [7:0] p0 [4] = '{default: 8'h00};
    logic [7:0] p1 [4] = '{default: 8'h00};
    logic [7:0] pm [4] = '{default: 8'h00};

    always @(posedge clk) begin
        p0[0] <= sb_si0;
        p1[0] <= sb_si1;
        pm[0] <= sb_r[7:0] ^ sb_r[31:24];
        for (int k = 1; k < 4; k++) begin
            p0[k] <= p0[k-1];
            p1[k] <= p1[k-1];
            pm[k] <= pm[k-1];
        end
    end

    assign sb_bo0 = sbox(p0[3] ^ p1[3]) ^ pm[3];
    assign sb_bo1 = pm[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fresh randomness every cycle, changed shortly after the active edge.
    initial begin
        rnd_i = 32'd0;
        forever begin
            @(posedge clk);
            #2 rnd_i = $urandom;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One full transaction: accept, watch RUN cycle by cycle, check DONE,
    // optionally stall the consumer, then hand the result off.
    task automatic do_run(input logic [127:0] a0, input logic [127:0] a1,
                          input logic [127:0] expv, input int stall);
        int guard;
        int bad;
        int nreq;
        int idx;
        logic [127:0] h0;
        logic [127:0] h1;
        logic [127:0] got;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_ready", {127'd0, in_ready}, 128'd1);
        chk("idle_quiet", {80'd0, sb_r, sb_si0, sb_si1}, 128'd0);
        s0_i = a0;
        s1_i = a1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
        bad = 0;
        nreq = 0;
        for (int c = 1; c <= 80; c++) begin
            idx = (c - 1) / 5;
            if (sb_si0 !== a0[8*(15-idx) +: 8] || sb_si1 !== a1[8*(15-idx) +: 8]) bad++;
            if (rnd_req === 1'b1) nreq++;
            if (sb_r !== rnd_i || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("run_seq", bad, 0);
        chk("rnd_req_cnt", nreq, 80);
        chk("latency_valid", {127'd0, out_valid}, 128'd1);
        chk("done_quiet", {94'd0, busy, rnd_req, sb_r}, 128'd0);
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
        chk("result", s0_o ^ s1_o, got);
        $display("run: s1=%h result=%h", a1, s0_o ^ s1_o);
        h0 = s0_o;
        h1 = s1_o;
        bad = 0;
        repeat (stall) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s0_o !== h0 || s1_o !== h1 || sb_r !== 32'd0)
                bad++;
        end
        if (stall > 0) chk("stall_hold", bad, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff", {126'd0, in_ready, out_valid}, 128'd2);
    endtask

    initial begin
        logic [127:0] r1;
        logic [127:0] q0 [3];
        logic [127:0] q1 [3];
        int nacc;
        int npop;
        int cyc;
        int last;
        bit pend;
        logic [127:0] got;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s0_i = '0;
        s1_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", {124'd0, in_ready, out_valid, busy, rnd_req}, 128'h8);
        chk("reset_bus", {80'd0, sb_si0, sb_si1, sb_r}, 128'd0);
        chk("reset_s0", s0_o, 128'd0);
        chk("reset_s1", s1_o, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero input: every byte becomes S(0x00) = 0x65; consumer stalls 20 cycles.
        do_run(128'd0, 128'd0, {16{8'h65}}, 20);

        // Share 0 = share 1 ^ 00 01 .. 0F, three different share-1 values.
        for (int s = 0; s < 3; s++) begin
            r1 = rand128();
            do_run(r1 ^ PAT, r1, sbox128(PAT), 0);
        end

        // Reset during RUN cycle 37: outputs clear asynchronously.
        s0_i = rand128();
        s1_i = rand128();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (36) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_flags", {124'd0, in_ready, out_valid, busy, rnd_req}, 128'h8);
        chk("async_rst_bus", {80'd0, sb_si0, sb_si1, sb_r}, 128'd0);
        chk("async_rst_s0", s0_o, 128'd0);
        chk("async_rst_s1", s1_o, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r1 = rand128();
        s0_i = rand128();
        do_run(s0_i, r1, sbox128(s0_i ^ r1), 0);

        // Back-to-back with out_ready tied high and in_valid held high.
        for (int k = 0; k < 3; k++) begin
            q0[k] = rand128();
            q1[k] = rand128();
        end
        nacc = 0;
        npop = 0;
        cyc = 0;
        last = 0;
        pend = 1'b0;
        s0_i = q0[0];
        s1_i = q1[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (npop < 3 && cyc < 600) begin
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(sbox128(q0[nacc] ^ q1[nacc]));
                if (nacc > 0) chk("b2b_gap", cyc - last, 82);
                last = cyc;
                nacc++;
                pend = 1'b1;
            end
            if (out_valid === 1'b1) begin
                got = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
                chk("b2b_result", s0_o ^ s1_o, got);
                $display("b2b: result=%h at cycle %0d", s0_o ^ s1_o, cyc);
                npop++;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (nacc < 3) begin
                    s0_i = q0[nacc];
                    s1_i = q1[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", npop, 3);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skinny_sbox8_cms1_subcells_ctrl.md
Name: skinny_sbox8_cms1_subcells_ctrl

Overview:
- Byte-serial SubCells sequencer for the 2-share (CMS1) Skinny-128-384+ datapath.
- Accepts a shared 128-bit state, feeds one byte at a time to the non-pipelined 8-bit CMS1 S-box core, and collects the shared S-box outputs back into the state.
- Holds each byte stable for the S-box's full register depth and forwards fresh 32-bit masks every active cycle.
- Sits between the round-state register and the S-box core, driving the core's inputs and consuming its outputs.

Parameters:
- HOLD, 5, cycles each byte is presented to the S-box: 4 AND-register layers plus 1 settle cycle. Must be >= 5.
- CNTW, 3, width of the hold counter. Must satisfy 2^CNTW > HOLD-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  shared state offered.
- in_ready  output  1  high in IDLE only.
- s0_i  input  128  share 0 of input state.
- s1_i  input  128  share 1 of input state.
- rnd_i  input  32  fresh randomness, valid whenever rnd_req is high.
- rnd_req  output  1  high in every RUN cycle.
- sb_si0  output  8  share 0 byte to the S-box.
- sb_si1  output  8  share 1 byte to the S-box.
- sb_r  output  32  mask to the S-box; equals rnd_i when rnd_req=1, else 0.
- sb_bo0  input  8  S-box share 0 output.
- sb_bo1  input  8  S-box share 1 output.
- out_valid  output  1  result available (DONE).
- out_ready  input  1  consumer accepts result.
- s0_o  output  128  share 0 of result; direct view of internal share-0 register.
- s1_o  output  128  share 1 of result; direct view of internal share-1 register.
- busy  output  1  high in RUN.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - Both share registers, byte index (4 bits) and hold counter clear to 0.
  - in_ready=1; out_valid, busy, rnd_req = 0.
  - sb_si0, sb_si1, sb_r, s0_o, s1_o = 0.
  - A reset mid-RUN discards the partial state; no output is produced.
- Byte order: cell i (i=0..15) occupies bits [127-8i : 120-8i]. Processing runs i=0 first, i=15 last.
- IDLE:
  - On in_valid & in_ready, latch s0_i/s1_i, clear idx and cnt, go to RUN.
  - No S-box activity. sb_si* and sb_r are 0, so the S-box sees constant zero shares.
- RUN:
  - sb_si0/sb_si1 are registered copies of cell idx of each share, valid from the first RUN cycle of that byte.
  - They stay constant for exactly HOLD cycles. cnt counts 0..HOLD-1.
  - rnd_req=1 and sb_r=rnd_i in every RUN cycle, including the capture cycle.
  - On the cnt=HOLD-1 edge:
    - Write sb_bo0/sb_bo1 into cell idx of share 0/share 1.
    - Clear cnt and increment idx.
    - On the same edge, update sb_si* to the next cell, taken from the not-yet-overwritten cell idx+1.
  - After capturing idx=15, go to DONE.
  - Total RUN duration is exactly 16*HOLD cycles (80 with the default).
- Share separation:
  - Share 0 and share 1 are never combined in any logic.
  - The byte muxes for share 0 and share 1 are separate.
  - No share crosses into the other share's register.
- DONE:
  - out_valid=1. s0_o/s1_o hold the result stable until out_ready.
  - On out_valid & out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
  - in_valid is ignored outside IDLE.
- Latency: 16*HOLD+1 cycles from the accept edge to out_valid.
- Throughput: one state per 16*HOLD+2 cycles when out_ready is held high.
- rnd_i is not checked. Supplying stale randomness is a caller error; the functional result is unaffected.

Test Plan:
- Reset, then accept s0_i=0, s1_i=0 -> after 81 cycles out_valid=1; s0_o^s1_o = 128'h6565…65 (sixteen bytes of 0x65, S(0x00)=0x65).
- Input with share 1 random and share 0 = share 1 ^ 128'h000102…0F, with a random rnd_i each cycle -> unmasked result = S applied per byte, e.g. byte 0 = 0x65, byte 1 = 0x4C, byte 15 = S(0x0F). Compare against a reference S-box model; result must be identical for 3 different share-1/rnd seeds.
- Sequencing -> sb_si0/sb_si1 change only on cycles 1+5k (k = 0..15) after accept. rnd_req is high for exactly 80 cycles. sb_r is 0 in IDLE and DONE.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1 and s0_o/s1_o stay stable. in_valid pulses during this window are ignored (in_ready=0).
- Assert rst at RUN cycle 37 -> all outputs 0 asynchronously, FSM in IDLE. A new accept afterwards produces the correct result for the new input only.
- Back-to-back runs with out_ready tied high and in_valid held high -> accepts occur exactly 82 cycles apart. Each unmasked result equals the reference S-box applied to its own input.
